feature_point_fetch: RTL and testbench

- Upstream feeder of the rectangle-sum/convolution stage.
- Accepts one Haar feature descriptor (3 rectangles plus weights) and a detection-window origin.
- Issues the 12 integral-image reads for that feature and forwards the returned data with point index and weight.
- Output stream matches the sum stage's ii_val/ii_data/num_point/weight interface exactly.

---
 rtl/feature_point_fetch_if.sv | 44 ++++
 rtl/feature_point_fetch.sv | 191 +++++++++++++++++++
 tb/tb_feature_point_fetch.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feature_point_fetch_if.sv
// ----------------------------------------------------------------------------
// feature_point_fetch_if
// Bundles the descriptor handshake, the integral-image read port and the
// point stream towards the rectangle-sum stage.
//   feat_val_i / feat_ready_o : descriptor handshake
//   win_x_i, win_y_i          : detection-window origin
//   rect_i                    : 3 x {x, y, w, h}, 5 bits each, rect k at [20k +: 20]
//   weight_i                  : {w1[1:0], w2[1:0]}
//   rd_en_o, rd_addr_o        : integral-image read request
//   rd_data_i                 : read data, RD_LAT cycles after rd_en_o
//   ii_val_o, ii_data_o       : point stream to the sum stage
//   num_point_o, weight_o     : point index {rect, corner} and feature weight
// master = the fetch block, slave = its environment.
// ----------------------------------------------------------------------------
interface feature_point_fetch_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
);
   logic              feat_val_i;
   logic              feat_ready_o;
   logic [8:0]        win_x_i;
   logic [8:0]        win_y_i;
   logic [59:0]       rect_i;
   logic [3:0]        weight_i;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [DATA_W-1:0] rd_data_i;
   logic              ii_val_o;
   logic [DATA_W-1:0] ii_data_o;
   logic [3:0]        num_point_o;
   logic [3:0]        weight_o;

   modport master (
      input  feat_val_i, win_x_i, win_y_i, rect_i, weight_i, rd_data_i,
      output feat_ready_o, rd_en_o, rd_addr_o, ii_val_o, ii_data_o,
             num_point_o, weight_o
   );

   modport slave (
      output feat_val_i, win_x_i, win_y_i, rect_i, weight_i, rd_data_i,
      input  feat_ready_o, rd_en_o, rd_addr_o, ii_val_o, ii_data_o,
             num_point_o, weight_o
   );
endinterface

// File: rtl/feature_point_fetch.sv
// ----------------------------------------------------------------------------
// feature_point_fetch
// Takes one Haar feature descriptor (3 rectangles + weights) and a window
// origin, issues the 12 integral-image corner reads one per cycle, and
// forwards the returned words tagged with point index and feature weight.
// A descriptor offered while the last read of the current feature issues is
// accepted in that cycle, giving an unbroken read stream.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous reset, active-high
//   fpf   : feature_point_fetch_if.master (handshake, read port, point stream)
// ----------------------------------------------------------------------------
module feature_point_fetch #(
   parameter int II_STRIDE = 321,
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   feature_point_fetch_if.master fpf
);

   localparam logic [3:0] LAST_PT = 4'd11;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   typedef struct packed {
      logic [4:0] x;
      logic [4:0] y;
      logic [4:0] w;
      logic [4:0] h;
   } rect_t;

   // One read in flight: valid, point index, weight of its feature.
   typedef struct packed {
      logic       vld;
      logic [3:0] pt;
      logic [3:0] wt;
   } tag_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        load;
   logic        accept;

   logic [8:0]  win_x_q, win_y_q;
   logic [59:0] rect_q;
   logic [3:0]  weight_q;

   // Descriptor seen by the address path for the next read.
   logic [8:0]  win_x_d, win_y_d;
   logic [59:0] rect_d;

   rect_t       sel;
   logic [4:0]  dx, dy;
   logic [31:0] col, row, addr_full;
   logic        rd_en_d;

   tag_t              dl_q [RD_LAT];
   tag_t              tail;
   logic [DATA_W-1:0] rd_data;

   assign fpf.feat_ready_o = (state_q == S_IDLE) ||
                             ((state_q == S_ISSUE) && (cnt_q == LAST_PT));
   assign accept  = fpf.feat_val_i && fpf.feat_ready_o;
   assign rd_data = fpf.rd_data_i;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ISSUE;
               cnt_d   = 4'd0;
               load    = 1'b1;
            end
         end
         S_ISSUE: begin
            if (cnt_q == LAST_PT) begin
               cnt_d = 4'd0;
               if (accept) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign rd_en_d = (state_d == S_ISSUE);

   // The read for cnt_d is formed one cycle early so rd_en_o/rd_addr_o can be
   // registered; on a load the fresh descriptor bypasses the latches.
   always_comb begin
      win_x_d = load ? fpf.win_x_i : win_x_q;
      win_y_d = load ? fpf.win_y_i : win_y_q;
      rect_d  = load ? fpf.rect_i  : rect_q;

      unique case (cnt_d[3:2])
         2'd1:    sel = rect_d[39:20];
         2'd2:    sel = rect_d[59:40];
         default: sel = rect_d[19:0];
      endcase

      // Corners 1 and 2 sit at x+w; corners 2 and 3 sit at y+h.
      dx = (cnt_d[1] ^ cnt_d[0]) ? sel.w : 5'd0;
      dy = cnt_d[1] ? sel.h : 5'd0;

      col       = 32'(win_x_d) + 32'(sel.x) + 32'(dx);
      row       = 32'(win_y_d) + 32'(sel.y) + 32'(dy);
      addr_full = row * 32'(II_STRIDE) + col;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         win_x_q       <= '0;
         win_y_q       <= '0;
         rect_q        <= '0;
         weight_q      <= '0;
         fpf.rd_en_o   <= 1'b0;
         fpf.rd_addr_o <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fpf.rd_en_o <= rd_en_d;
         if (load) begin
            win_x_q  <= fpf.win_x_i;
            win_y_q  <= fpf.win_y_i;
            rect_q   <= fpf.rect_i;
            weight_q <= fpf.weight_i;
         end
         if (rd_en_d) begin
            fpf.rd_addr_o <= addr_full[ADDR_W-1:0];
         end
      end
   end

   // NOTE: the delay line is reset because it carries valid bits; clearing
   // it is what stops stale points after a mid-feature reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < RD_LAT; i++) begin
            dl_q[i] <= '0;
         end
      end else begin
         dl_q[0] <= {fpf.rd_en_o, cnt_q, weight_q};
         for (int i = 1; i < RD_LAT; i++) begin
            dl_q[i] <= dl_q[i-1];
         end
      end
   end

   assign tail = dl_q[RD_LAT-1];

   // Weight travels with each read so it changes exactly at point 0 of the
   // feature it belongs to, whatever RD_LAT is.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fpf.ii_val_o    <= 1'b0;
         fpf.ii_data_o   <= '0;
         fpf.num_point_o <= '0;
         fpf.weight_o    <= '0;
      end else begin
         fpf.ii_val_o <= tail.vld;
         if (tail.vld) begin
            fpf.ii_data_o   <= rd_data;
            fpf.num_point_o <= tail.pt;
            if (tail.pt == 4'd0) begin
               fpf.weight_o <= tail.wt;
            end
         end
      end
   end

endmodule

// File: tb/tb_feature_point_fetch.sv
// ----------------------------------------------------------------------------
// tb_feature_point_fetch
// Directed and random descriptors against a reference that derives every
// corner address and stream timing from the feature geometry. A memory model
// returns the read address as data (0xBAD0BAD0 on cycles with no read due).
// ----------------------------------------------------------------------------
module tb_feature_point_fetch;

   localparam int II_STRIDE = 321;
   localparam int ADDR_W    = 17;
   localparam int DATA_W    = 32;
   localparam int RD_LAT    = 2;
   localparam int DRAIN     = 12 + RD_LAT + 4;

   typedef struct {
      int          cyc;
      logic [31:0] val;
      logic [3:0]  pt;
      logic [3:0]  wt;
   } ev_t;

   logic clk_i = 1'b0;
   logic rst_i;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   ev_t rd_log[$], ii_log[$], exp_rd[$], exp_ii[$];

   logic [ADDR_W:0] mem_pipe [RD_LAT];

   feature_point_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   feature_point_fetch #(
      .II_STRIDE(II_STRIDE),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RD_LAT   (RD_LAT)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .fpf  (bus)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Memory: data for a read issued in cycle C is presented in cycle C+RD_LAT.
   always @(posedge clk_i) begin
      mem_pipe[0] <= {bus.rd_en_o, bus.rd_addr_o};
      for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
   end
   assign bus.rd_data_i = mem_pipe[RD_LAT-1][ADDR_W] ?
                          DATA_W'(mem_pipe[RD_LAT-1][ADDR_W-1:0]) : 32'hBAD0_BAD0;

   // Output monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (bus.rd_en_o === 1'b1)
         rd_log.push_back('{cyc, 32'(bus.rd_addr_o), 4'd0, 4'd0});
      if (bus.ii_val_o === 1'b1)
         ii_log.push_back('{cyc, bus.ii_data_o, bus.num_point_o, bus.weight_o});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Corner address from the feature geometry.
   function automatic logic [31:0] ref_addr(input logic [8:0] wx, input logic [8:0] wy,
                                            input logic [59:0] rect, input int idx);
      int k, c, x, y, w, h, col, row;
      logic [59:0] r;
      k   = idx / 4;
      c   = idx % 4;
      r   = rect >> (20 * k);
      x   = int'(r[19:15]);
      y   = int'(r[14:10]);
      w   = int'(r[9:5]);
      h   = int'(r[4:0]);
      col = int'(wx) + x + ((c == 1 || c == 2) ? w : 0);
      row = int'(wy) + y + ((c >= 2) ? h : 0);
      return 32'((row * II_STRIDE + col) % (1 << ADDR_W));
   endfunction

   // Offer a descriptor; expect acceptance after exp_wait stalled cycles.
   // Returns at the first read cycle of the accepted feature.
   task automatic send(input logic [8:0] wx, input logic [8:0] wy, input logic [59:0] rect,
                       input logic [3:0] wt, input int exp_wait, output int t_acc);
      int  waited;
      bit  done;
      logic [31:0] a;
      waited = 0;
      done   = 1'b0;
      t_acc  = -1;
      bus.win_x_i    = wx;
      bus.win_y_i    = wy;
      bus.rect_i     = rect;
      bus.weight_i   = wt;
      bus.feat_val_i = 1'b1;
      while (!done && waited < 40) begin
         @(negedge clk_i);
         if (bus.feat_ready_o === 1'b1) begin
            done  = 1'b1;
            t_acc = cyc;
         end else begin
            waited++;
         end
      end
      check("accept wait", waited, exp_wait);
      @(posedge clk_i);
      #1;
      bus.feat_val_i = 1'b0;
      if (done) begin
         for (int i = 0; i < 12; i++) begin
            a = ref_addr(wx, wy, rect, i);
            exp_rd.push_back('{t_acc + 1 + i, a, 4'd0, 4'd0});
            exp_ii.push_back('{t_acc + RD_LAT + 2 + i, a, 4'(i), wt});
         end
      end
   endtask

   task automatic prune(input int limit);
      ev_t tmp[$];
      tmp = {};
      foreach (exp_rd[i]) if (exp_rd[i].cyc < limit) tmp.push_back(exp_rd[i]);
      exp_rd = tmp;
      tmp = {};
      foreach (exp_ii[i]) if (exp_ii[i].cyc < limit) tmp.push_back(exp_ii[i]);
      exp_ii = tmp;
   endtask

   task automatic compare_logs(input string tag);
      int n;
      check({tag, " read count"}, rd_log.size(), exp_rd.size());
      n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s rd%0d cycle", tag, i), rd_log[i].cyc, exp_rd[i].cyc);
         check($sformatf("%s rd%0d addr", tag, i), rd_log[i].val, exp_rd[i].val);
      end
      check({tag, " point count"}, ii_log.size(), exp_ii.size());
      n = (ii_log.size() < exp_ii.size()) ? ii_log.size() : exp_ii.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s pt%0d cycle", tag, i), ii_log[i].cyc, exp_ii[i].cyc);
         check($sformatf("%s pt%0d data", tag, i), ii_log[i].val, exp_ii[i].val);
         check($sformatf("%s pt%0d index", tag, i), ii_log[i].pt, exp_ii[i].pt);
         check($sformatf("%s pt%0d weight", tag, i), ii_log[i].wt, exp_ii[i].wt);
      end
      rd_log.delete();
      ii_log.delete();
      exp_rd.delete();
      exp_ii.delete();
   endtask

   initial begin
      int t, ta, tb;
      int c4[4];
      logic [59:0] rect;
      bit b2b;

      c4 = '{7395, 7399, 9004, 9000};
      rst_i          = 1'b1;
      bus.feat_val_i = 1'b0;
      bus.win_x_i    = '0;
      bus.win_y_i    = '0;
      bus.rect_i     = '0;
      bus.weight_i   = '0;

      // Reset state
      idle(3);
      check("reset feat_ready", bus.feat_ready_o, 1);
      check("reset rd_en", bus.rd_en_o, 0);
      check("reset ii_val", bus.ii_val_o, 0);
      check("reset weight", bus.weight_o, 0);
      rst_i = 1'b0;
      idle(2);
      check("post-reset feat_ready", bus.feat_ready_o, 1);
      check("post-reset rd_en", bus.rd_en_o, 0);
      check("post-reset ii_val", bus.ii_val_o, 0);
      check("post-reset weight", bus.weight_o, 0);
      check("post-reset num_point", bus.num_point_o, 0);
      check("post-reset ii_data", bus.ii_data_o, 0);
      rd_log.delete();
      ii_log.delete();

      // Single feature with known corner addresses
      rect = {28'($urandom), 32'($urandom)};
      rect[19:0] = {5'd2, 5'd3, 5'd4, 5'd5};
      send(9'd10, 9'd20, rect, 4'b0110, 0, t);
      idle(DRAIN);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("single rd_addr c%0d", i),
               (i < rd_log.size()) ? rd_log[i].val : 32'hFFFF_FFFF, c4[i]);
         check($sformatf("single rd cycle c%0d", i),
               (i < rd_log.size()) ? rd_log[i].cyc : -1, t + 1 + i);
         check($sformatf("single ii_data c%0d", i),
               (i < ii_log.size()) ? ii_log[i].val : 32'hFFFF_FFFF, c4[i]);
         check($sformatf("single ii cycle c%0d", i),
               (i < ii_log.size()) ? ii_log[i].cyc : -1, t + 4 + i);
      end
      if (exp_ii.size() == 12) begin
         check("hold ii_data", bus.ii_data_o, exp_ii[11].val);
         check("hold num_point", bus.num_point_o, 11);
         check("hold weight", bus.weight_o, 4'b0110);
      end
      compare_logs("single");

      // Back-to-back: second descriptor held valid during ISSUE
      send(9'($urandom), 9'($urandom), {28'($urandom), 32'($urandom)}, 4'b0011, 0, ta);
      send(9'($urandom), 9'($urandom), {28'($urandom), 32'($urandom)}, 4'b1100, 11, tb);
      check("b2b accept spacing", tb - ta, 12);
      idle(DRAIN);
      compare_logs("b2b");

      // Descriptor pulse mid-ISSUE must be ignored
      send(9'($urandom), 9'($urandom), {28'($urandom), 32'($urandom)}, 4'b0101, 0, t);
      idle(3);
      bus.rect_i     = ~bus.rect_i;
      bus.win_x_i    = ~bus.win_x_i;
      bus.weight_i   = ~bus.weight_i;
      bus.feat_val_i = 1'b1;
      @(negedge clk_i);
      check("mid-issue feat_ready", bus.feat_ready_o, 0);
      @(posedge clk_i);
      #1;
      bus.feat_val_i = 1'b0;
      idle(DRAIN);
      compare_logs("mid pulse");

      // Reset while cnt == 5
      send(9'($urandom), 9'($urandom), {28'($urandom), 32'($urandom)}, 4'b1110, 0, t);
      idle(5);
      rst_i = 1'b1;
      #1;
      check("abort rd_en", bus.rd_en_o, 0);
      check("abort ii_val", bus.ii_val_o, 0);
      check("abort feat_ready", bus.feat_ready_o, 1);
      prune(t + 6);
      idle(2);
      rst_i = 1'b0;
      idle(20);
      compare_logs("reset abort");
      send(9'($urandom), 9'($urandom), {28'($urandom), 32'($urandom)}, 4'b0111, 0, t);
      idle(DRAIN);
      compare_logs("after reset");

      // Zero-size rect 2 still yields all 12 points
      send(9'($urandom), 9'($urandom), {20'd0, 40'({$urandom, $urandom})}, 4'b1001, 0, t);
      idle(DRAIN);
      compare_logs("zero rect2");

      // Random descriptors, random gaps or back-to-back
      for (int n = 0; n < 24; n++) begin
         b2b = (n > 0) && ($urandom_range(0, 1) == 1);
         if (!b2b && n > 0) idle(12 + $urandom_range(0, 3));
         send(9'($urandom), 9'($urandom), {28'($urandom), 32'($urandom)}, 4'($urandom),
              b2b ? 11 : 0, t);
      end
      idle(DRAIN);
      compare_logs("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
